// File: rtl/dispatcher_pkg.sv
// Shared types and default sizing for the ticket dispatcher.
package dispatcher_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam int DT_SZ_DEF = 4;
    localparam int CNTER_DEF = 3;

endpackage

// File: rtl/dispatcher_prio_enc.sv
// Lowest-index-first priority encoder over the free-counter vector.
module dispatcher_prio_enc #(
    parameter int N = 3
) (
    input  logic [N-1:0] free,
    output logic [N-1:0] grant,
    output logic         any_free
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (free[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any_free = |free;

endmodule

// File: rtl/dispatcher.sv
// Pops tickets from a FWFT FIFO and loads each into the lowest-index free
// counter; a SETTLE cycle after every dispatch lets FIFO and counter update.
module dispatcher
    import dispatcher_pkg::*;
#(
    parameter int DT_SZ = DT_SZ_DEF,
    parameter int CNTER = CNTER_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             empty,
    input  logic [DT_SZ-1:0] qn,
    input  logic [DT_SZ-1:0] qt,
    input  logic [CNTER-1:0] busy,
    output logic             re,
    output logic [CNTER-1:0] ld,
    output logic [DT_SZ-1:0] dn,
    output logic [DT_SZ-1:0] dt
);

    state_t            state_q, state_d;
    logic              re_q, re_d;
    logic [CNTER-1:0]  ld_q, ld_d;
    logic [DT_SZ-1:0]  dn_q, dn_d;
    logic [DT_SZ-1:0]  dt_q, dt_d;

    logic [CNTER-1:0]  free;
    logic [CNTER-1:0]  grant;
    logic              any_free;

    assign free = ~busy;

    dispatcher_prio_enc #(
        .N (CNTER)
    ) u_prio_enc (
        .free     (free),
        .grant    (grant),
        .any_free (any_free)
    );

    always_comb begin
        state_d = state_q;
        re_d    = 1'b0;
        ld_d    = '0;
        dn_d    = dn_q;
        dt_d    = dt_q;
        case (state_q)
            IDLE: begin
                if (!empty && any_free) begin
                    re_d    = 1'b1;
                    ld_d    = grant;
                    dn_d    = qn;
                    dt_d    = qt;
                    state_d = SETTLE;
                end
            end
            // Inputs are ignored here: FIFO head and busy bits are still moving.
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            re_q    <= 1'b0;
            ld_q    <= '0;
            dn_q    <= '0;
            dt_q    <= '0;
        end else begin
            state_q <= state_d;
            re_q    <= re_d;
            ld_q    <= ld_d;
            dn_q    <= dn_d;
            dt_q    <= dt_d;
        end
    end

    assign re = re_q;
    assign ld = ld_q;
    assign dn = dn_q;
    assign dt = dt_q;

endmodule

// File: tb/tb_dispatcher.sv
// Randomized and directed bench for dispatcher against a ticket-level model.
module tb_dispatcher;

    logic       clk;
    logic       rst;
    logic       empty;
    logic [3:0] qn;
    logic [3:0] qt;
    logic [2:0] busy;
    logic       re;
    logic [2:0] ld;
    logic [3:0] dn;
    logic [3:0] dt;

    int tests;
    int fails;

    // Model state: was the previous edge a dispatch, and last delivered ticket.
    bit         m_settle;
    logic [3:0] m_dn;
    logic [3:0] m_dt;
    logic       exp_re;
    logic [2:0] exp_ld;
    int         n_pulses;

    logic [3:0] fifo_n[$];
    logic [3:0] fifo_t[$];

    dispatcher dut (
        .clk   (clk),
        .rst   (rst),
        .empty (empty),
        .qn    (qn),
        .qt    (qt),
        .busy  (busy),
        .re    (re),
        .ld    (ld),
        .dn    (dn),
        .dt    (dt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [2:0] lowest_free(input logic [2:0] b);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            if (!b[i]) r = 3'b000 | (3'b001 << i);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_settle = 1'b0;
        m_dn     = 4'd0;
        m_dt     = 4'd0;
    endtask

    task automatic check_all(input string tag);
        tests++;
        if (re !== exp_re) begin
            fails++;
            $display("FAIL %s re: got %0b want %0b", tag, re, exp_re);
        end
        tests++;
        if (ld !== exp_ld) begin
            fails++;
            $display("FAIL %s ld: got %03b want %03b", tag, ld, exp_ld);
        end
        tests++;
        if (dn !== m_dn) begin
            fails++;
            $display("FAIL %s dn: got %0d want %0d", tag, dn, m_dn);
        end
        tests++;
        if (dt !== m_dt) begin
            fails++;
            $display("FAIL %s dt: got %0d want %0d", tag, dt, m_dt);
        end
    endtask

    // One clock: predict from inputs present at the edge, then compare 1 ns later.
    task automatic step(input string tag);
        @(posedge clk);
        if (!m_settle && !empty && busy != 3'b111) begin
            exp_re   = 1'b1;
            exp_ld   = lowest_free(busy);
            m_dn     = qn;
            m_dt     = qt;
            m_settle = 1'b1;
        end else begin
            exp_re   = 1'b0;
            exp_ld   = 3'b000;
            m_settle = 1'b0;
        end
        #1;
        if (re === 1'b1) n_pulses++;
        check_all(tag);
    endtask

    task automatic test_reset();
        exp_re = 1'b0;
        exp_ld = 3'b000;
        model_reset();
        #5  check_all("reset_t5");
        #6  check_all("reset_edge1");
        #20 check_all("reset_edge2");
        #4  rst = 1'b0;
        #1  check_all("reset_release");
    endtask

    task automatic test_all_busy();
        empty = 1'b0; qn = 4'd10; qt = 4'd3; busy = 3'b111;
        for (int i = 0; i < 5; i++) step("all_busy");
    endtask

    task automatic test_single(input logic [3:0] n, input logic [3:0] t,
                               input logic [2:0] b, input string tag);
        empty = 1'b0; qn = n; qt = t; busy = b;
        step(tag);
        empty = 1'b1;
        for (int i = 0; i < 3; i++) step(tag);
    endtask

    task automatic test_back_to_back();
        logic [2:0] prev_ld;
        prev_ld = 3'b000;
        empty = 1'b0; busy = 3'b000;
        for (int i = 0; i < 8; i++) begin
            qn = 4'(i + 1); qt = 4'(15 - i);
            step("b2b");
            tests++;
            if (prev_ld != 3'b000 && ld != 3'b000) begin
                fails++;
                $display("FAIL b2b_consecutive ld: got %03b after %03b want 000", ld, prev_ld);
            end
            prev_ld = ld;
        end
    endtask

    task automatic test_async_reset();
        int guard;
        empty = 1'b0; busy = 3'b000; qn = 4'd9; qt = 4'd6;
        guard = 0;
        do begin
            step("arst_pre");
            guard++;
        end while (ld !== 3'b001 && guard < 6);
        tests++;
        if (ld !== 3'b001) begin
            fails++;
            $display("FAIL arst_wait ld: got %03b want 001", ld);
        end
        rst = 1'b1;
        #2;
        exp_re = 1'b0;
        exp_ld = 3'b000;
        model_reset();
        check_all("arst_async");
        #5 rst = 1'b0;
        empty = 1'b1;
        for (int i = 0; i < 2; i++) step("arst_post");
    endtask

    task automatic test_random();
        int pushed;
        int start_pulses;
        pushed = 0;
        start_pulses = n_pulses;
        fifo_n.delete();
        fifo_t.delete();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0 && fifo_n.size() < 8) begin
                fifo_n.push_back(4'($urandom));
                fifo_t.push_back(4'($urandom));
                pushed++;
            end
            busy  = 3'($urandom);
            empty = (fifo_n.size() == 0);
            qn    = empty ? 4'($urandom) : fifo_n[0];
            qt    = empty ? 4'($urandom) : fifo_t[0];
            step("random");
            if (re === 1'b1 && fifo_n.size() != 0) begin
                void'(fifo_n.pop_front());
                void'(fifo_t.pop_front());
            end
        end
        tests++;
        if (n_pulses - start_pulses != pushed - fifo_n.size()) begin
            fails++;
            $display("FAIL random_count pulses: got %0d want %0d",
                     n_pulses - start_pulses, pushed - fifo_n.size());
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        n_pulses = 0;
        rst   = 1'b1;
        empty = 1'b1;
        busy  = 3'b111;
        qn    = 4'd0;
        qt    = 4'd0;
        test_reset();
        test_all_busy();
        test_single(4'd11, 4'd2, 3'b110, "busy110");
        test_single(4'd12, 4'd4, 3'b101, "busy101");
        test_single(4'd13, 4'd1, 3'b011, "busy011");
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
